// File: rtl/ev19_rom_arbiter.sv
// ---------------------------------------------------------------------------
// ev19_rom_arbiter
//
// Shares the single-port 4096x32 boot/program ROM between the EV19 core
// instruction-fetch master (if_*) and the data/debug master (d_*).
// One access per cycle, round-robin on contention, 1-cycle read latency
// (the ROM registers its address; its q output is combinational).
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   if_read/if_address   fetch read request and word address
//   if_waitrequest       fetch request not accepted this cycle
//   if_readdata/_valid   fetch read return (valid one cycle after accept)
//   d_read/d_write       data-port read / debug-patch write request
//   d_address            data-port word address
//   d_byteenable         write byte enables (reads always use all bytes)
//   d_writedata          write data
//   d_debugaccess        debug qualifier passed to the ROM
//   d_waitrequest        data request not accepted this cycle
//   d_readdata/_valid    data-port read return
//   freeze               1 = accept no new requests
//   rom_*                ROM macro interface (address, byteenable,
//                        chipselect, write, writedata, debugaccess, readdata)
//
// Handshake: a side's request is accepted in the cycle where req = 1 and
// waitrequest = 0. waitrequest = req & ~grant, so it is 0 while the side is
// idle. A read accepted in cycle N returns readdatavalid = 1 with the data in
// cycle N+1 for exactly one cycle; writes never return anything.
// ---------------------------------------------------------------------------
module ev19_rom_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   // fetch port
   input  logic              if_read,
   input  logic [ADDR_W-1:0] if_address,
   output logic              if_waitrequest,
   output logic [DATA_W-1:0] if_readdata,
   output logic              if_readdatavalid,
   // data / debug port
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [BE_W-1:0]   d_byteenable,
   input  logic [DATA_W-1:0] d_writedata,
   input  logic              d_debugaccess,
   output logic              d_waitrequest,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_readdatavalid,
   // global hold-off
   input  logic              freeze,
   // ROM macro
   output logic [ADDR_W-1:0] rom_address,
   output logic [BE_W-1:0]   rom_byteenable,
   output logic              rom_chipselect,
   output logic              rom_write,
   output logic [DATA_W-1:0] rom_writedata,
   output logic              rom_debugaccess,
   input  logic [DATA_W-1:0] rom_readdata
);

   // Which side owns the read data returning from the ROM this cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Winner of the most recent contention cycle.
   typedef enum logic {
      SIDE_IF = 1'b0,
      SIDE_D  = 1'b1
   } side_t;

   owner_t owner_q, owner_d;
   side_t  last_win_q, last_win_d;

   logic if_req;
   logic d_req;
   logic blocked;
   logic grant_if;
   logic grant_d;
   logic d_is_write;

   assign if_req     = if_read;
   assign d_req      = d_read | d_write;
   // A data-port request with both strobes set is treated as a write.
   assign d_is_write = d_write;
   // Reset and freeze both suppress every grant; waitrequest then mirrors req.
   assign blocked    = reset | freeze;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         last_win_q <= SIDE_D;   // fetch wins the first contention
      end else begin
         owner_q    <= owner_d;
         last_win_q <= last_win_d;
      end
   end

   // ------------------------------------------------------------------------
   // Grant, ROM drive and next-state
   // ------------------------------------------------------------------------
   always_comb begin
      grant_if        = 1'b0;
      grant_d         = 1'b0;
      owner_d         = OWN_NONE;
      last_win_d      = last_win_q;
      rom_address     = if_address;
      rom_byteenable  = {BE_W{1'b1}};
      rom_chipselect  = 1'b0;
      rom_write       = 1'b0;
      rom_writedata   = d_writedata;
      rom_debugaccess = 1'b0;

      if (!blocked) begin
         if (if_req && d_req) begin
            // Contention: the side that did not win last time goes now.
            if (last_win_q == SIDE_D) begin
               grant_if   = 1'b1;
               last_win_d = SIDE_IF;
            end else begin
               grant_d    = 1'b1;
               last_win_d = SIDE_D;
            end
         end else if (if_req) begin
            grant_if = 1'b1;
         end else if (d_req) begin
            grant_d = 1'b1;
         end
      end

      if (grant_if) begin
         rom_chipselect = 1'b1;
         rom_address    = if_address;
         owner_d        = OWN_IF;
      end else if (grant_d) begin
         rom_chipselect  = 1'b1;
         rom_address     = d_address;
         rom_debugaccess = d_debugaccess;
         if (d_is_write) begin
            // Forwarded even without debugaccess; the ROM itself drops it.
            rom_write      = 1'b1;
            rom_byteenable = d_byteenable;
         end else begin
            owner_d = OWN_D;
         end
      end
   end

   assign if_waitrequest = if_req & ~grant_if;
   assign d_waitrequest  = d_req & ~grant_d;

   // Returning data is dropped while reset is high, including a read that
   // was accepted in the cycle just before reset rose.
   assign if_readdatavalid = (owner_q == OWN_IF) & ~reset;
   assign d_readdatavalid  = (owner_q == OWN_D) & ~reset;

   // Both read ports see the ROM output directly; only the valids qualify it.
   assign if_readdata = rom_readdata;
   assign d_readdata  = rom_readdata;

endmodule

// File: tb/tb_ev19_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ev19_rom_arbiter
//
// Directed bench for ev19_rom_arbiter with a behavioural ROM (registered
// address, combinational q, byte-enabled write gated by debugaccess).
// ROM word i is preloaded with {20'hC0DE0, i}. The driver checks the
// combinational handshake mid-cycle and pushes {return_cycle, data} into a
// per-side expected queue for every read it expects to be accepted; the
// monitor pops and compares whenever a readdatavalid appears.
// ---------------------------------------------------------------------------
module tb_ev19_rom_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic              if_read;
   logic [ADDR_W-1:0] if_address;
   logic              if_waitrequest;
   logic [DATA_W-1:0] if_readdata;
   logic              if_readdatavalid;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [BE_W-1:0]   d_byteenable;
   logic [DATA_W-1:0] d_writedata;
   logic              d_debugaccess;
   logic              d_waitrequest;
   logic [DATA_W-1:0] d_readdata;
   logic              d_readdatavalid;
   logic              freeze;
   logic [ADDR_W-1:0] rom_address;
   logic [BE_W-1:0]   rom_byteenable;
   logic              rom_chipselect;
   logic              rom_write;
   logic [DATA_W-1:0] rom_writedata;
   logic              rom_debugaccess;
   logic [DATA_W-1:0] rom_readdata;

   ev19_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_read          (if_read),
      .if_address       (if_address),
      .if_waitrequest   (if_waitrequest),
      .if_readdata      (if_readdata),
      .if_readdatavalid (if_readdatavalid),
      .d_read           (d_read),
      .d_write          (d_write),
      .d_address        (d_address),
      .d_byteenable     (d_byteenable),
      .d_writedata      (d_writedata),
      .d_debugaccess    (d_debugaccess),
      .d_waitrequest    (d_waitrequest),
      .d_readdata       (d_readdata),
      .d_readdatavalid  (d_readdatavalid),
      .freeze           (freeze),
      .rom_address      (rom_address),
      .rom_byteenable   (rom_byteenable),
      .rom_chipselect   (rom_chipselect),
      .rom_write        (rom_write),
      .rom_writedata    (rom_writedata),
      .rom_debugaccess  (rom_debugaccess),
      .rom_readdata     (rom_readdata)
   );

   // ---------------- ROM model ----------------
   logic [DATA_W-1:0] mem [0:4095];
   logic [ADDR_W-1:0] rom_addr_q = '0;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {20'hC0DE0, i[11:0]};
   end

   always @(posedge clk) begin
      if (rom_chipselect) begin
         rom_addr_q <= rom_address;
         if (rom_write && rom_debugaccess) begin
            for (int b = 0; b < BE_W; b++)
               if (rom_byteenable[b]) mem[rom_address][8*b +: 8] <= rom_writedata[8*b +: 8];
         end
      end
   end
   assign rom_readdata = mem[rom_addr_q];

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [47:0] exp_if_q[$];
   logic [47:0] exp_d_q[$];

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every valid must match the oldest expected entry, including
   // the cycle in which it was supposed to arrive.
   always @(negedge clk) begin
      logic [47:0] e_if;
      logic [47:0] e_d;
      if (if_readdatavalid === 1'b1) begin
         if (exp_if_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL if_unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e_if = exp_if_q.pop_front();
            chk("if_return", {16'(cyc), if_readdata}, e_if);
         end
      end
      if (d_readdatavalid === 1'b1) begin
         if (exp_d_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d_unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e_d = exp_d_q.pop_front();
            chk("d_return", {16'(cyc), d_readdata}, e_d);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      if_read       = 1'b0;
      if_address    = '0;
      d_read        = 1'b0;
      d_write       = 1'b0;
      d_address     = '0;
      d_byteenable  = '0;
      d_writedata   = '0;
      d_debugaccess = 1'b0;
      freeze        = 1'b0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle handshake check; queues an expected return when a read
   // acceptance is expected on a side.
   task automatic step(input string nm, input logic exp_if_wr, input logic exp_d_wr,
                       input logic exp_cs, input logic [ADDR_W-1:0] exp_addr,
                       input logic push_if, input logic push_d,
                       input logic [DATA_W-1:0] exp_data);
      @(negedge clk);
      chk({nm, "_if_wait"}, 48'(if_waitrequest), 48'(exp_if_wr));
      chk({nm, "_d_wait"}, 48'(d_waitrequest), 48'(exp_d_wr));
      chk({nm, "_cs"}, 48'(rom_chipselect), 48'(exp_cs));
      if (exp_cs) chk({nm, "_addr"}, 48'(rom_address), 48'(exp_addr));
      if (push_if) exp_if_q.push_back({16'(cyc + 1), exp_data});
      if (push_d)  exp_d_q.push_back({16'(cyc + 1), exp_data});
   endtask

   task automatic set_both(input logic [ADDR_W-1:0] a_if, input logic [ADDR_W-1:0] a_d);
      if_read    = 1'b1;
      if_address = a_if;
      d_read     = 1'b1;
      d_address  = a_d;
   endtask

   task automatic set_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dat,
                            input logic [BE_W-1:0] be, input logic dbg);
      idle();
      d_write       = 1'b1;
      d_address     = a;
      d_writedata   = dat;
      d_byteenable  = be;
      d_debugaccess = dbg;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      reset = 1'b1;
      set_both(12'h001, 12'h002);
      @(posedge clk);
      #1;
      // reset state: grants suppressed, nothing returned
      step("rst", 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      chk("rst_rom_write", 48'(rom_write), 48'h0);
      chk("rst_if_valid", 48'(if_readdatavalid), 48'h0);
      chk("rst_d_valid", 48'(d_readdatavalid), 48'h0);
      adv();
      reset = 1'b0;
      idle();
      adv();

      // 1: lone fetch read
      if_read = 1'b1; if_address = 12'h010;
      step("t1", 1'b0, 1'b0, 1'b1, 12'h010, 1'b1, 1'b0, 32'hC0DE0010);
      adv();
      idle();
      adv();

      // 2: both requesting for 4 cycles -> IF, D, IF, D
      set_both(12'h001, 12'h100);
      step("t2a", 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 32'hC0DE0001); adv();
      step("t2b", 1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 1'b1, 32'hC0DE0100); adv();
      step("t2c", 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 32'hC0DE0001); adv();
      step("t2d", 1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 1'b1, 32'hC0DE0100); adv();
      idle();
      adv();

      // 3: debug writes, full word then low half
      set_write(12'h020, 32'hDEADBEEF, 4'hF, 1'b1);
      step("t3w1", 1'b0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b0, 32'h0);
      chk("t3w1_rom_write", 48'(rom_write), 48'h1);
      chk("t3w1_be", 48'(rom_byteenable), 48'hF);
      adv();
      idle();
      if_read = 1'b1; if_address = 12'h020;
      step("t3r1", 1'b0, 1'b0, 1'b1, 12'h020, 1'b1, 1'b0, 32'hDEADBEEF);
      chk("t3r1_be", 48'(rom_byteenable), 48'hF);
      adv();
      set_write(12'h020, 32'h00001234, 4'h3, 1'b1);
      step("t3w2", 1'b0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b0, 32'h0);
      chk("t3w2_be", 48'(rom_byteenable), 48'h3);
      adv();
      idle();
      if_read = 1'b1; if_address = 12'h020;
      step("t3r2", 1'b0, 1'b0, 1'b1, 12'h020, 1'b1, 1'b0, 32'hDEAD1234);
      adv();

      // 4: write without debugaccess is accepted but leaves the ROM alone
      set_write(12'h020, 32'h00000000, 4'hF, 1'b0);
      step("t4w", 1'b0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b0, 32'h0);
      chk("t4w_rom_write", 48'(rom_write), 48'h1);
      chk("t4w_dbg", 48'(rom_debugaccess), 48'h0);
      adv();
      idle();
      d_read = 1'b1; d_address = 12'h020;
      step("t4r", 1'b0, 1'b0, 1'b1, 12'h020, 1'b0, 1'b1, 32'hDEAD1234);
      adv();
      idle();
      adv();

      // 5: freeze right after an IF accept; order resumes with D next
      set_both(12'h030, 12'h040);
      step("t5a", 1'b0, 1'b1, 1'b1, 12'h030, 1'b1, 1'b0, 32'hC0DE0030); adv();
      freeze = 1'b1;
      step("t5f1", 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0); adv();
      step("t5f2", 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0); adv();
      freeze = 1'b0;
      step("t5r1", 1'b1, 1'b0, 1'b1, 12'h040, 1'b0, 1'b1, 32'hC0DE0040); adv();
      step("t5r2", 1'b0, 1'b1, 1'b1, 12'h030, 1'b1, 1'b0, 32'hC0DE0030); adv();
      idle();
      adv();

      // 6: reset the cycle after a D accept; that return is dropped
      d_read = 1'b1; d_address = 12'h050;
      step("t6a", 1'b0, 1'b0, 1'b1, 12'h050, 1'b0, 1'b0, 32'h0); adv();
      reset = 1'b1;
      set_both(12'h060, 12'h050);
      step("t6rst", 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      chk("t6rst_d_valid", 48'(d_readdatavalid), 48'h0);
      adv();
      reset = 1'b0;
      step("t6b", 1'b0, 1'b1, 1'b1, 12'h060, 1'b1, 1'b0, 32'hC0DE0060); adv();
      step("t6c", 1'b1, 1'b0, 1'b1, 12'h050, 1'b0, 1'b1, 32'hC0DE0050); adv();
      idle();
      adv();
      adv();

      // every expected return must have been seen
      chk("if_queue_drained", 48'(exp_if_q.size()), 48'h0);
      chk("d_queue_drained", 48'(exp_d_q.size()), 48'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
